// File: rtl/data_mem_sized_if.sv
// Request/response bundle for data_mem_sized: one request per cycle while
// ready is high, and a registered response one cycle later.
interface data_mem_sized_if #(
    parameter int ADDR_BITS = 13
);
    logic                 en;
    logic                 wr;
    logic [1:0]           size;
    logic                 sign_ext;
    logic [ADDR_BITS-1:0] addr;
    logic [63:0]          d_in;
    logic [63:0]          d_out;
    logic                 valid;
    logic                 misalign;
    logic                 ready;

    modport master (
        output en, wr, size, sign_ext, addr, d_in,
        input  d_out, valid, misalign, ready
    );

    modport slave (
        input  en, wr, size, sign_ext, addr, d_in,
        output d_out, valid, misalign, ready
    );
endinterface

// File: rtl/data_mem_sized.sv
// 64-bit word memory with byte/half/word/double loads and stores, alignment
// checking and an optional post-reset clear sweep.
module data_mem_sized #(
    parameter int ADDR_BITS      = 13,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    data_mem_sized_if.slave   bus
);
    localparam int WORD_BITS = ADDR_BITS - 3;
    localparam int NWORDS    = 1 << WORD_BITS;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t               state_q;
    logic [WORD_BITS-1:0] clr_cnt_q;
    logic                 ready_q;
    logic                 valid_q;
    logic                 misalign_q;
    logic [63:0]          d_out_q;
    logic [63:0]          mem_q [0:NWORDS-1];

    logic [WORD_BITS-1:0] idx;
    logic [2:0]           off;
    logic                 aligned;
    logic [7:0]           size_mask;
    logic [7:0]           lane_mask;
    logic [63:0]          word_rd;
    logic [63:0]          wdata_sh;
    logic [63:0]          merged_d;
    logic [63:0]          result_d;
    logic                 accept;

    function automatic logic [63:0] extend(input logic [63:0] v,
                                           input logic [1:0]  sz,
                                           input logic        sx);
        logic [63:0] r;
        case (sz)
            2'b00:   r = {{56{sx & v[7]}},  v[7:0]};
            2'b01:   r = {{48{sx & v[15]}}, v[15:0]};
            2'b10:   r = {{32{sx & v[31]}}, v[31:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    always_comb begin
        idx       = bus.addr[ADDR_BITS-1:3];
        off       = bus.addr[2:0];
        aligned   = 1'b1;
        size_mask = 8'h01;
        case (bus.size)
            2'b00: begin aligned = 1'b1;         size_mask = 8'h01; end
            2'b01: begin aligned = ~off[0];      size_mask = 8'h03; end
            2'b10: begin aligned = ~|off[1:0];   size_mask = 8'h0F; end
            default: begin aligned = (off == 3'd0); size_mask = 8'hFF; end
        endcase
        lane_mask = size_mask << off;
        word_rd   = mem_q[idx];
        wdata_sh  = bus.d_in << {off, 3'b000};
        merged_d  = word_rd;
        for (int unsigned b = 0; b < 8; b++) begin
            if (lane_mask[b]) begin
                merged_d[b*8 +: 8] = wdata_sh[b*8 +: 8];
            end
        end
        // Store responses echo d_in through the same extension a load would apply.
        result_d = extend(bus.wr ? bus.d_in : (word_rd >> {off, 3'b000}),
                          bus.size, bus.sign_ext);
        accept   = ready_q & bus.en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR_ON_RESET ? CLEAR : IDLE;
            clr_cnt_q  <= '0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            d_out_q    <= '0;
        end else begin
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                CLEAR: begin
                    mem_q[clr_cnt_q] <= '0;
                    clr_cnt_q        <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == '1) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        valid_q    <= 1'b1;
                        misalign_q <= ~aligned;
                        d_out_q    <= aligned ? result_d : '0;
                        if (aligned && bus.wr) begin
                            mem_q[idx] <= merged_d;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.d_out    = d_out_q;
    assign bus.valid    = valid_q;
    assign bus.misalign = misalign_q;
    assign bus.ready    = ready_q;
endmodule

// File: doc/data_mem_sized.md
DATA_MEM_SIZED -- requirements
Module: data_mem_sized

Interface
- REQ-001 SHALL have parameter ADDR_BITS, default 13, byte-address width; memory holds 2**(ADDR_BITS-3) 64-bit words.
- REQ-002 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = zero all words after reset, 0 = no clear.
- REQ-003 SHALL use one clock; reset is synchronous and active-high.
- REQ-004 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
- REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
- REQ-006 SHALL have port en, input, 1: access request; sampled only when ready=1.
- REQ-007 SHALL have port wr, input, 1: 1 = store, 0 = load.
- REQ-008 SHALL have port size, input, 2: 00 byte, 01 half, 10 word, 11 double.
- REQ-009 SHALL have port sign_ext, input, 1: load result sign-extended when 1, zero-extended when 0.
- REQ-010 SHALL have port addr, input, ADDR_BITS: byte address; word index addr[ADDR_BITS-1:3], offset addr[2:0].
- REQ-011 SHALL have port d_in, input, 64: store data, right-justified (low bytes used).
- REQ-012 SHALL have port d_out, output, 64: registered result.
- REQ-013 SHALL have port valid, output, 1: one-cycle pulse, d_out/misalign meaningful.
- REQ-014 SHALL have port misalign, output, 1: access was misaligned; qualified by valid.
- REQ-015 SHALL have port ready, output, 1: block accepts requests.

Function
- REQ-016 SHALL implement FSM states CLEAR and IDLE; reset enters CLEAR (CLEAR_ON_RESET=1) or IDLE (0).
- REQ-017 In CLEAR, SHALL write 0 to word clr_cnt each cycle, clr_cnt from 0 up; after the last word, next state IDLE; ready=0 throughout CLEAR.
- REQ-018 In IDLE, ready=1; a request is accepted when en=1.
- REQ-019 Access SHALL be aligned iff offset is a multiple of access size (byte always; half offset[0]=0; word offset[1:0]=0; double offset=0).
- REQ-020 Aligned store SHALL write only the 1/2/4/8 bytes starting at byte lane offset (lane 0 = bits 7:0), taking d_in low bytes; other bytes of the word unchanged.
- REQ-021 Aligned load SHALL extract the addressed bytes and sign- or zero-extend to 64 bits per sign_ext (size 11 ignores sign_ext).
- REQ-022 Latency SHALL be one cycle: request accepted at edge N -> valid=1, d_out, misalign at edge N+1 (visible cycle after N); valid=0 otherwise.
- REQ-023 Store SHALL return on d_out the stored value extended per sign_ext, as a later load of the same size would return.
- REQ-024 Misaligned access SHALL not modify memory; response valid=1, misalign=1, d_out=0.
- REQ-025 Back-to-back requests every cycle SHALL be supported; a load immediately after a store to the same word SHALL see the stored bytes.
- REQ-026 d_out SHALL hold its last value while valid=0.
- REQ-027 en while ready=0 SHALL be ignored: no write, no response.

Reset
- REQ-028 On rst=1: d_out=0, valid=0, misalign=0, ready=0, clr_cnt=0; state per REQ-016 (CLEAR_ON_RESET=0: ready=1 the cycle after rst falls).
- REQ-029 rst during CLEAR SHALL restart the clear from word 0; rst has priority over any request.
- REQ-030 Memory contents SHALL not be reset except by the CLEAR sequence.

Verification (ADDR_BITS=6, 8 words, CLEAR_ON_RESET=1)
- REQ-031 Reset, hold en=1 -> ready=0 exactly 8 cycles after rst falls, no valid; then double loads of addr 0x00..0x38 return 0.
- REQ-032 Store double 0x8877665544332211 @0x08, then load byte @0x0F sign_ext=1 -> d_out=0xFFFFFFFFFFFFFF88; sign_ext=0 -> 0x88.
- REQ-033 Store half 0xBEEF @0x12 over zero word, load double @0x10 -> 0x00000000BEEF0000; store response d_out=0xFFFFFFFFFFFFBEEF with sign_ext=1.
- REQ-034 Store word @0x22 -> valid=1, misalign=1, d_out=0; load double @0x20 -> 0, misalign=0.
- REQ-035 Assert rst mid-CLEAR at cycle 4 -> clear restarts, ready rises 8 cycles after second rst release.
- REQ-036 Store byte 0x5A @0x31 then load byte @0x31 next cycle, sign_ext=0 -> valid pulse each cycle, second d_out=0x5A.
